// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states,
// datapath mux selects, ALU operations and trap causes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRPC   = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;

  // Immediate format is a pure function of the opcode; unknown opcodes fall to I.
  function automatic logic [2:0] imm_src_for(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_JAL:           return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:          return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request plus instruction funct fields onto the
// datapath ALU operation code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [3:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type from I-type, where bit 30 is an immediate bit
          3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alucontrol = ALU_SLL;
          3'b010:  alucontrol = ALU_SLT;
          3'b011:  alucontrol = ALU_SLTU;
          3'b100:  alucontrol = ALU_XOR;
          3'b101:  alucontrol = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alucontrol = ALU_OR;
          default: alucontrol = ALU_AND;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences each instruction through the shared
// memory and datapath, with a per-access timeout and a sticky trap state.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memread,
  output logic       memwrite,
  output logic       adrsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic [2:0] immsrc,
  output logic [3:0] alucontrol,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state_dbg
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t     state_reg, state_next, dispatch;
  logic [7:0] wait_cnt_reg;
  logic [1:0] cause_reg, cause_next;
  logic [1:0] aluop;
  logic       pcwrite_raw, irwrite_raw, regwrite_raw, memread_raw, memwrite_raw;
  logic       mem_req, cond, taken;

  always_comb begin
    dispatch = S_TRAP;
    case (op)
      OP_LOAD:   if (funct3 == 3'b010) dispatch = S_MEMADR;
      OP_STORE:  if (funct3 == 3'b010) dispatch = S_MEMADR;
      OP_RTYPE:  dispatch = S_EXECR;
      OP_ITYPE:  dispatch = S_EXECI;
      OP_BRANCH: if (funct3[2:1] != 2'b01) dispatch = S_BRANCH;
      OP_JAL:    dispatch = S_JAL;
      OP_JALR:   if (funct3 == 3'b000) dispatch = S_JALR;
      OP_LUI:    dispatch = S_LUI;
      OP_AUIPC:  dispatch = S_AUIPC;
      default:   dispatch = S_TRAP;
    endcase
  end

  // funct3[0] inverts the base comparison (bne/bge/bgeu)
  always_comb begin
    cond = 1'b0;
    case (funct3[2:1])
      2'b00:   cond = zero;
      2'b10:   cond = lt;
      2'b11:   cond = ltu;
      default: cond = 1'b0;
    endcase
    taken = cond ^ funct3[0];
  end

  always_comb begin
    state_next   = state_reg;
    cause_next   = cause_reg;
    pcwrite_raw  = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    memread_raw  = 1'b0;
    memwrite_raw = 1'b0;
    mem_req      = 1'b0;
    adrsrc       = 1'b0;
    alusrca      = SRCA_PC;
    alusrcb      = SRCB_RS2;
    resultsrc    = RES_ALUOUT;
    aluop        = ALUOP_ADD;
    case (state_reg)
      S_FETCH: begin
        memread_raw = 1'b1;
        mem_req     = 1'b1;
        alusrcb     = SRCB_FOUR;
        resultsrc   = RES_ALURESULT;
        if (mem_ready) begin
          irwrite_raw = 1'b1;
          pcwrite_raw = 1'b1;
          state_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrca    = SRCA_OLDPC;
        alusrcb    = SRCB_IMM;
        state_next = dispatch;
        if (dispatch == S_TRAP) cause_next = CAUSE_ILLEGAL;
      end
      S_MEMADR: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_IMM;
        state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrsrc      = 1'b1;
        memread_raw = 1'b1;
        mem_req     = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc    = RES_READDATA;
        regwrite_raw = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEMWRITE: begin
        adrsrc       = 1'b1;
        memwrite_raw = 1'b1;
        mem_req      = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        alusrca    = SRCA_RS1;
        aluop      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_IMM;
        aluop      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_raw = 1'b1;
        state_next   = S_FETCH;
      end
      S_BRANCH: begin
        alusrca     = SRCA_RS1;
        aluop       = ALUOP_SUB;
        pcwrite_raw = taken;
        state_next  = S_FETCH;
      end
      S_JAL, S_JALRPC: begin
        alusrca     = SRCA_OLDPC;
        alusrcb     = SRCB_FOUR;
        pcwrite_raw = 1'b1;
        state_next  = S_ALUWB;
      end
      S_JALR: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_IMM;
        state_next = S_JALRPC;
      end
      S_LUI: begin
        alusrca    = SRCA_ZERO;
        alusrcb    = SRCB_IMM;
        state_next = S_ALUWB;
      end
      S_AUIPC: begin
        alusrca    = SRCA_OLDPC;
        alusrcb    = SRCB_IMM;
        state_next = S_ALUWB;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_TRAP;
    endcase
    // a ready on the last permitted wait cycle still completes the access
    if (mem_req && !mem_ready && (wait_cnt_reg == WAIT_LAST)) begin
      state_next = S_TRAP;
      cause_next = CAUSE_BUS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_FETCH;
      wait_cnt_reg <= 8'd0;
      cause_reg    <= CAUSE_NONE;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
      if (state_next != state_reg) wait_cnt_reg <= 8'd0;
      else if (mem_req && !mem_ready) wait_cnt_reg <= wait_cnt_reg + 8'd1;
    end
  end

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alucontrol (alucontrol)
  );

  assign pcwrite    = pcwrite_raw  & rst_n;
  assign irwrite    = irwrite_raw  & rst_n;
  assign regwrite   = regwrite_raw & rst_n;
  assign memread    = memread_raw  & rst_n;
  assign memwrite   = memwrite_raw & rst_n;
  assign immsrc     = imm_src_for(op);
  assign trap       = (state_reg == S_TRAP);
  assign trap_cause = cause_reg;
  assign state_dbg  = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction-level bench: each instruction class expands into its
// expected state walk, and every cycle's outputs are compared to that walk.
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;

  localparam int MEM_WAIT_MAX = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0, lt = 1'b0, ltu = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pcwrite, irwrite, regwrite, memread, memwrite, adrsrc, trap;
  logic [1:0] alusrca, alusrcb, resultsrc, trap_cause;
  logic [2:0] immsrc;
  logic [3:0] alucontrol, state_dbg;

  int checks = 0;
  int errors = 0;
  int instr_idx = 0;
  int cyc_count = 0;

  logic [2:0] cur_imm;
  logic [3:0] cur_alu;
  logic       cur_taken;
  logic [1:0] cur_cause;

  typedef enum int {C_R, C_I, C_LW, C_SW, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL} cls_t;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .irwrite(irwrite), .regwrite(regwrite), .memread(memread),
    .memwrite(memwrite), .adrsrc(adrsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .resultsrc(resultsrc), .immsrc(immsrc), .alucontrol(alucontrol), .trap(trap),
    .trap_cause(trap_cause), .state_dbg(state_dbg)
  );

  wire [25:0] obs = {pcwrite, irwrite, regwrite, memread, memwrite, adrsrc, alusrca,
                     alusrcb, resultsrc, immsrc, alucontrol, trap, trap_cause, state_dbg};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_alu(input bit is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0: return (is_r && f7) ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return f7 ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic [2:0] ref_imm(input logic [6:0] o);
    if (o == OP_STORE) return 3'b001;
    if (o == OP_BRANCH) return 3'b010;
    if (o == OP_JAL) return 3'b011;
    if (o == OP_LUI || o == OP_AUIPC) return 3'b100;
    return 3'b000;
  endfunction

  function automatic bit known_op(input logic [6:0] o);
    return o == OP_LOAD || o == OP_STORE || o == OP_RTYPE || o == OP_ITYPE ||
           o == OP_BRANCH || o == OP_JAL || o == OP_JALR || o == OP_LUI || o == OP_AUIPC;
  endfunction

  // Expected control word for one cycle spent in step s.
  function automatic logic [25:0] expect_cycle(input state_t s, input logic rdy);
    logic pcw = 0, irw = 0, rw = 0, mr = 0, mw = 0, adr = 0, tr = 0;
    logic [1:0] sa = 0, sb = 0, rs = 0;
    logic [3:0] alu = 0;
    case (s)
      S_FETCH:    begin mr = 1; sb = 2; rs = 2; pcw = rdy; irw = rdy; end
      S_DECODE:   begin sa = 1; sb = 1; end
      S_MEMADR:   begin sa = 2; sb = 1; end
      S_MEMREAD:  begin adr = 1; mr = 1; end
      S_MEMWB:    begin rs = 1; rw = 1; end
      S_MEMWRITE: begin adr = 1; mw = 1; end
      S_EXECR:    begin sa = 2; alu = cur_alu; end
      S_EXECI:    begin sa = 2; sb = 1; alu = cur_alu; end
      S_ALUWB:    rw = 1;
      S_BRANCH:   begin sa = 2; alu = 4'd1; pcw = cur_taken; end
      S_JAL, S_JALRPC: begin sa = 1; sb = 2; pcw = 1; end
      S_JALR:     begin sa = 2; sb = 1; end
      S_LUI:      begin sa = 3; sb = 1; end
      S_AUIPC:    begin sa = 1; sb = 1; end
      default:    tr = 1;
    endcase
    return {pcw, irw, rw, mr, mw, adr, sa, sb, rs, cur_imm, alu, tr,
            (s == S_TRAP) ? cur_cause : 2'b00, 4'(s)};
  endfunction

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cycle(input state_t s, input logic rdy);
    mem_ready = rdy;
    @(negedge clk);
    check_eq($sformatf("i%0d_%s", instr_idx, s.name()), 32'(obs), 32'(expect_cycle(s, rdy)));
    @(posedge clk);
    #1;
    cyc_count++;
  endtask

  task automatic access(input state_t s, input int w, output logic timed_out);
    timed_out = 1'b0;
    for (int i = 0; i < w && i < MEM_WAIT_MAX; i++) cycle(s, 1'b0);
    if (w >= MEM_WAIT_MAX) timed_out = 1'b1;
    else cycle(s, 1'b1);
  endtask

  task automatic apply_reset();
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq($sformatf("i%0d_reset", instr_idx),
             {20'd0, pcwrite, irwrite, regwrite, memread, memwrite, trap, trap_cause, state_dbg},
             {20'd0, 8'd0, 4'(S_FETCH)});
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    rst_n = 1'b1;
    cur_cause = 2'b00;
  endtask

  task automatic do_trap(input logic [1:0] cause);
    cur_cause = cause;
    for (int i = 0; i < 3; i++) cycle(S_TRAP, 1'($urandom_range(0, 1)));
    apply_reset();
  endtask

  function automatic int pick_wait();
    int r = $urandom_range(0, 15);
    if (r < 10) return r % 4;
    if (r < 13) return 0;
    if (r == 13) return 14;
    if (r == 14) return 15;
    return 1;
  endfunction

  task automatic run_instr(input cls_t c, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input int fw, input int mw,
                           input logic [31:0] a, input logic [31:0] b);
    logic to;
    int start = cyc_count;
    op = o; funct3 = f3; funct7b5 = f7;
    zero = (a == b); lt = ($signed(a) < $signed(b)); ltu = (a < b);
    case (f3)
      3'd0: cur_taken = (a == b);
      3'd1: cur_taken = (a != b);
      3'd4: cur_taken = ($signed(a) < $signed(b));
      3'd5: cur_taken = !($signed(a) < $signed(b));
      3'd6: cur_taken = (a < b);
      default: cur_taken = !(a < b);
    endcase
    cur_imm = ref_imm(o);
    cur_alu = ref_alu(c == C_R, f3, f7);
    cur_cause = 2'b00;
    access(S_FETCH, fw, to);
    if (to) do_trap(2'b10);
    else begin
      cycle(S_DECODE, 1'($urandom_range(0, 1)));
      case (c)
        C_R:     begin cycle(S_EXECR, 1'b1); cycle(S_ALUWB, 1'b0); end
        C_I:     begin cycle(S_EXECI, 1'b0); cycle(S_ALUWB, 1'b1); end
        C_LW: begin
          cycle(S_MEMADR, 1'b1);
          access(S_MEMREAD, mw, to);
          if (to) do_trap(2'b10); else cycle(S_MEMWB, 1'b0);
        end
        C_SW: begin
          cycle(S_MEMADR, 1'b0);
          access(S_MEMWRITE, mw, to);
          if (to) do_trap(2'b10);
        end
        C_BR:    cycle(S_BRANCH, 1'b1);
        C_JAL:   begin cycle(S_JAL, 1'b0); cycle(S_ALUWB, 1'b1); end
        C_JALR:  begin cycle(S_JALR, 1'b1); cycle(S_JALRPC, 1'b0); cycle(S_ALUWB, 1'b0); end
        C_LUI:   begin cycle(S_LUI, 1'b1); cycle(S_ALUWB, 1'b0); end
        C_AUIPC: begin cycle(S_AUIPC, 1'b0); cycle(S_ALUWB, 1'b1); end
        default: do_trap(2'b01);
      endcase
    end
    $display("instr %0d %s op=%h f3=%0d f7b5=%0d fetch_wait=%0d mem_wait=%0d cycles=%0d",
             instr_idx, c.name(), o, f3, f7, fw, mw, cyc_count - start);
    instr_idx++;
  endtask

  task automatic run_random();
    cls_t c = cls_t'($urandom_range(0, 9));
    logic [6:0] o = OP_RTYPE;
    logic [2:0] f3 = 3'($urandom_range(0, 7));
    logic f7 = 1'($urandom_range(0, 1));
    logic [31:0] a = $urandom;
    logic [31:0] b = ($urandom_range(0, 2) == 0) ? a : $urandom;
    int k;
    case (c)
      C_R:     o = OP_RTYPE;
      C_I:     o = OP_ITYPE;
      C_LW:    begin o = OP_LOAD;  f3 = 3'd2; end
      C_SW:    begin o = OP_STORE; f3 = 3'd2; end
      C_BR:    begin o = OP_BRANCH; if (f3[2:1] == 2'b01) f3[2] = 1'b1; end
      C_JAL:   o = OP_JAL;
      C_JALR:  begin o = OP_JALR; f3 = 3'd0; end
      C_LUI:   o = OP_LUI;
      C_AUIPC: o = OP_AUIPC;
      default: begin
        k = $urandom_range(0, 3);
        if (k == 0) begin
          o = 7'($urandom);
          for (int g = 0; g < 64 && known_op(o); g++) o = 7'($urandom);
          if (known_op(o)) o = 7'h7F;
        end else if (k == 1) begin
          o = $urandom_range(0, 1) ? OP_LOAD : OP_STORE;
          f3 = 3'(2 + $urandom_range(1, 7));
        end else if (k == 2) begin
          o = OP_BRANCH; f3 = {2'b01, 1'($urandom_range(0, 1))};
        end else begin
          o = OP_JALR; f3 = 3'($urandom_range(1, 7));
        end
      end
    endcase
    run_instr(c, o, f3, f7, pick_wait(), pick_wait(), a, b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    cur_imm = 3'b000; cur_alu = 4'd0; cur_taken = 1'b0; cur_cause = 2'b00;
    #3;
    apply_reset();
    // directed: add, lw with 3 waits, beq taken, bltu not taken, lui
    run_instr(C_R, OP_RTYPE, 3'd0, 1'b0, 0, 0, 32'd1, 32'd2);
    run_instr(C_LW, OP_LOAD, 3'd2, 1'b0, 0, 3, 32'd0, 32'd0);
    run_instr(C_BR, OP_BRANCH, 3'd0, 1'b0, 0, 0, 32'd7, 32'd7);
    run_instr(C_BR, OP_BRANCH, 3'd6, 1'b0, 0, 0, 32'd9, 32'd3);
    run_instr(C_LUI, OP_LUI, 3'd3, 1'b0, 0, 0, 32'd0, 32'd1);
    run_instr(C_R, OP_RTYPE, 3'd0, 1'b1, 1, 0, 32'd0, 32'd1);
    run_instr(C_I, OP_ITYPE, 3'd5, 1'b1, 0, 0, 32'd0, 32'd1);
    run_instr(C_I, OP_ITYPE, 3'd0, 1'b1, 0, 0, 32'd0, 32'd1);
    run_instr(C_JALR, OP_JALR, 3'd0, 1'b0, 2, 0, 32'd0, 32'd1);
    run_instr(C_SW, OP_STORE, 3'd2, 1'b0, 0, 14, 32'd0, 32'd1);
    run_instr(C_ILL, 7'h7F, 3'd0, 1'b0, 0, 0, 32'd0, 32'd1);
    run_instr(C_R, OP_RTYPE, 3'd4, 1'b0, 15, 0, 32'd0, 32'd1);
    run_instr(C_LW, OP_LOAD, 3'd2, 1'b0, 0, 15, 32'd0, 32'd1);

    // reset while a store is waiting on memory
    op = OP_STORE; funct3 = 3'd2; funct7b5 = 1'b0;
    cur_imm = 3'b001; cur_alu = 4'd0; cur_cause = 2'b00;
    cycle(S_FETCH, 1'b1);
    cycle(S_DECODE, 1'b0);
    cycle(S_MEMADR, 1'b0);
    cycle(S_MEMWRITE, 1'b0);
    #1;
    check_eq("memwrite_before_reset", 32'(memwrite), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("memwrite_in_reset", 32'({memwrite, trap, state_dbg}), 32'({1'b0, 1'b0, 4'(S_FETCH)}));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("instr %0d reset_mid_memwrite", instr_idx);
    instr_idx++;

    for (int n = 0; n < 70; n++) run_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
